// File: rtl/frame_write_scheduler.sv
// Round-robin pixel-write arbiter that counts a frame and swaps buffers on the vsync falling edge.
// Optional range check on accepted addresses: define FRAME_WRITE_ADDR_CHECK_EN.
module frame_write_scheduler #(
    parameter int NUM_CORES    = 4,
    parameter int WIDTH        = 4,
    parameter int ADDR_LEN     = 17,
    parameter int FRAME_PIXELS = 76800
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CORES-1:0]            core_valid,
    input  logic [NUM_CORES*ADDR_LEN-1:0]   core_addr,
    input  logic [NUM_CORES*WIDTH-1:0]      core_data,
    output logic [NUM_CORES-1:0]            core_ready,
    input  logic                            vsync_in,
    output logic                            write_enable,
    output logic [ADDR_LEN-1:0]             write_addr,
    output logic [WIDTH-1:0]                write_data,
    output logic                            swap_buffers,
    output logic [15:0]                     frame_count,
    output logic                            wait_vsync,
    output logic                            addr_err
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = ADDR_LEN + 1;
    localparam logic [CNT_W-1:0] FRAME_LIMIT = CNT_W'(FRAME_PIXELS);

    typedef enum logic [1:0] {
        RENDER,
        WAIT_VSYNC,
        SWAP
    } state_t;

    state_t               state, state_next;
    logic [PTR_W-1:0]     rr_ptr;
    logic [CNT_W-1:0]     pixel_count;
    logic [CNT_W-1:0]     count_next;
    logic                 vsync_q, vsync_prev;
    logic                 vsync_fall;

    logic                 grant_found;
    logic [PTR_W-1:0]     grant_idx;
    logic [ADDR_LEN-1:0]  sel_addr;
    logic [WIDTH-1:0]     sel_data;
    logic                 accept;
    logic                 addr_ok;
    logic                 do_write;

    // Two passes give round-robin priority: first cores at or above the pointer, then the wrap-around.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        sel_addr    = '0;
        sel_data    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!grant_found && core_valid[i] && (PTR_W'(i) >= rr_ptr)) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(i);
                sel_addr    = core_addr[i*ADDR_LEN +: ADDR_LEN];
                sel_data    = core_data[i*WIDTH +: WIDTH];
            end
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!grant_found && core_valid[i] && (PTR_W'(i) < rr_ptr)) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(i);
                sel_addr    = core_addr[i*ADDR_LEN +: ADDR_LEN];
                sel_data    = core_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign accept = (state == RENDER) && grant_found && !rst;

    always_comb begin
        core_ready = '0;
        if (accept) begin
            core_ready[grant_idx] = 1'b1;
        end
    end

`ifdef FRAME_WRITE_ADDR_CHECK_EN
    logic addr_err_q;

    // Out-of-range requests are still consumed so a faulty core cannot wedge the arbiter.
    assign addr_ok = ({1'b0, sel_addr} < FRAME_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err_q <= 1'b0;
        end else if (accept && !addr_ok) begin
            addr_err_q <= 1'b1;
        end
    end

    assign addr_err = addr_err_q;
`else
    assign addr_ok  = 1'b1;
    assign addr_err = 1'b0;
`endif

    assign do_write   = accept && addr_ok;
    assign count_next = pixel_count + 1'b1;
    assign vsync_fall = vsync_prev && !vsync_q;

    always_comb begin
        state_next = state;
        case (state)
            RENDER: begin
                if (do_write && (count_next == FRAME_LIMIT)) begin
                    state_next = WAIT_VSYNC;
                end
            end
            WAIT_VSYNC: begin
                if (vsync_fall) begin
                    state_next = SWAP;
                end
            end
            SWAP:    state_next = RENDER;
            default: state_next = RENDER;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RENDER;
            rr_ptr       <= '0;
            pixel_count  <= '0;
            frame_count  <= '0;
            vsync_q      <= 1'b1;
            vsync_prev   <= 1'b1;
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
        end else begin
            state        <= state_next;
            vsync_q      <= vsync_in;
            vsync_prev   <= vsync_q;
            write_enable <= do_write;
            if (do_write) begin
                write_addr <= sel_addr;
                write_data <= sel_data;
            end
            if (accept) begin
                rr_ptr <= (grant_idx == PTR_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (state == SWAP) begin
                pixel_count <= '0;
                frame_count <= frame_count + 16'd1;
            end else if (do_write) begin
                pixel_count <= count_next;
            end
        end
    end

    assign swap_buffers = (state == SWAP);
    assign wait_vsync   = (state == WAIT_VSYNC);

endmodule

// File: tb/tb_frame_write_scheduler.sv
// Directed bench for frame_write_scheduler with FRAME_PIXELS=8 and four cores.
// Expectations adapt to FRAME_WRITE_ADDR_CHECK_EN when the bench is built with it.
module tb_frame_write_scheduler;

    localparam int NUM_CORES    = 4;
    localparam int WIDTH        = 4;
    localparam int ADDR_LEN     = 17;
    localparam int FRAME_PIXELS = 8;
`ifdef FRAME_WRITE_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NUM_CORES-1:0]          core_valid;
    logic [NUM_CORES*ADDR_LEN-1:0] core_addr;
    logic [NUM_CORES*WIDTH-1:0]    core_data;
    logic [NUM_CORES-1:0]          core_ready;
    logic                          vsync_in;
    logic                          write_enable;
    logic [ADDR_LEN-1:0]           write_addr;
    logic [WIDTH-1:0]              write_data;
    logic                          swap_buffers;
    logic [15:0]                   frame_count;
    logic                          wait_vsync;
    logic                          addr_err;

    int passed = 0;
    int total  = 0;
    int grants [8] = '{0, 1, 2, 3, 0, 2, 3, 0};

    frame_write_scheduler #(
        .NUM_CORES    (NUM_CORES),
        .WIDTH        (WIDTH),
        .ADDR_LEN     (ADDR_LEN),
        .FRAME_PIXELS (FRAME_PIXELS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .core_valid   (core_valid),
        .core_addr    (core_addr),
        .core_data    (core_data),
        .core_ready   (core_ready),
        .vsync_in     (vsync_in),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .swap_buffers (swap_buffers),
        .frame_count  (frame_count),
        .wait_vsync   (wait_vsync),
        .addr_err     (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Each step starts just after a rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Expects vsync_in high for at least two prior cycles and the DUT in WAIT_VSYNC.
    task automatic vsync_fall_swap(input logic [15:0] fc);
        vsync_in = 1'b0;
        settle();
        check("swap_edge0", 32'(swap_buffers), 32'd0);
        tick();
        settle();
        check("swap_edge1", 32'(swap_buffers), 32'd0);
        check("wait_edge1", 32'(wait_vsync), 32'd1);
        tick();
        settle();
        check("swap_pulse", 32'(swap_buffers), 32'd1);
        check("swap_ready", 32'(core_ready), 32'd0);
        check("swap_we", 32'(write_enable), 32'd0);
        tick();
        settle();
        check("swap_after", 32'(swap_buffers), 32'd0);
        check("frame_count", 32'(frame_count), 32'(fc));
        check("wait_after", 32'(wait_vsync), 32'd0);
        tick();
    endtask

    task automatic accept_cycles(input int n, input logic [NUM_CORES-1:0] mask);
        for (int k = 0; k < n; k++) begin
            core_valid = mask;
            tick();
        end
        core_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        vsync_in   = 1'b1;
        core_valid = '1;
        for (int i = 0; i < NUM_CORES; i++) begin
            core_addr[i*ADDR_LEN +: ADDR_LEN] = ADDR_LEN'(i + 4);
            core_data[i*WIDTH +: WIDTH]       = WIDTH'(i + 10);
        end

        // Reset cycle: no grants even with all cores requesting.
        settle();
        check("rst_ready", 32'(core_ready), 32'd0);
        tick();
        rst = 1'b0;

        // Frame 1: round-robin across all cores, then core 1 drops out.
        for (int i = 0; i < 8; i++) begin
            core_valid = (i < 5) ? 4'hF : 4'hD;
            settle();
            check("grant", 32'(core_ready), 32'(1 << grants[i]));
            if (i == 0) begin
                check("we_first", 32'(write_enable), 32'd0);
                check("fc_reset", 32'(frame_count), 32'd0);
                check("err_reset", 32'(addr_err), 32'd0);
            end else begin
                check("we", 32'(write_enable), 32'd1);
                check("waddr", 32'(write_addr), 32'(grants[i-1] + 4));
                check("wdata", 32'(write_data), 32'(grants[i-1] + 10));
            end
            check("wait_render", 32'(wait_vsync), 32'd0);
            tick();
        end

        // Last write lands in the first WAIT_VSYNC cycle.
        settle();
        check("wv_ready", 32'(core_ready), 32'd0);
        check("wv_wait", 32'(wait_vsync), 32'd1);
        check("wv_we", 32'(write_enable), 32'd1);
        check("wv_waddr", 32'(write_addr), 32'd4);
        check("wv_swap", 32'(swap_buffers), 32'd0);
        tick();
        for (int j = 0; j < 4; j++) begin
            settle();
            check("hold_ready", 32'(core_ready), 32'd0);
            check("hold_wait", 32'(wait_vsync), 32'd1);
            check("hold_we", 32'(write_enable), 32'd0);
            check("hold_swap", 32'(swap_buffers), 32'd0);
            tick();
        end
        core_valid = '0;
        vsync_fall_swap(16'd1);

        // Frame 2: vsync already low at the final accept; pointer resumes at core 1.
        for (int k = 0; k < 8; k++) begin
            core_valid = 4'hF;
            settle();
            check("f2_grant", 32'(core_ready), 32'(1 << ((1 + k) % 4)));
            tick();
        end
        core_valid = '0;
        for (int j = 0; j < 4; j++) begin
            settle();
            check("f2_wait_low", 32'(wait_vsync), 32'd1);
            check("f2_noswap_low", 32'(swap_buffers), 32'd0);
            tick();
        end
        vsync_in = 1'b1;
        for (int j = 0; j < 3; j++) begin
            settle();
            check("f2_noswap_high", 32'(swap_buffers), 32'd0);
            tick();
        end
        vsync_fall_swap(16'd2);

        // Reset while waiting for vsync discards the frame.
        vsync_in = 1'b1;
        accept_cycles(8, 4'hF);
        settle();
        check("pre_rst_wait", 32'(wait_vsync), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("rst_wait", 32'(wait_vsync), 32'd0);
        check("rst_fc", 32'(frame_count), 32'd0);
        check("rst_swap", 32'(swap_buffers), 32'd0);
        tick();
        vsync_in = 1'b0;
        for (int j = 0; j < 3; j++) begin
            settle();
            check("rst_noswap", 32'(swap_buffers), 32'd0);
            tick();
        end
        vsync_in = 1'b1;
        accept_cycles(7, 4'hF);
        tick();
        tick();
        vsync_in = 1'b0;
        for (int j = 0; j < 4; j++) begin
            settle();
            check("partial_noswap", 32'(swap_buffers), 32'd0);
            check("partial_wait", 32'(wait_vsync), 32'd0);
            tick();
        end
        vsync_in = 1'b1;
        accept_cycles(1, 4'hF);
        settle();
        check("full_wait", 32'(wait_vsync), 32'd1);
        tick();
        tick();
        tick();
        vsync_fall_swap(16'd1);

        // Out-of-range address from core 2.
        core_addr[2*ADDR_LEN +: ADDR_LEN] = ADDR_LEN'(9);
        core_data[2*WIDTH +: WIDTH]       = WIDTH'(5);
        core_valid = 4'b0100;
        settle();
        check("oor_ready", 32'(core_ready), 32'd4);
        tick();
        core_valid = '0;
        settle();
        check("oor_we", 32'(write_enable), CHK ? 32'd0 : 32'd1);
        if (!CHK) begin
            check("oor_waddr", 32'(write_addr), 32'd9);
            check("oor_wdata", 32'(write_data), 32'd5);
        end
        check("oor_err", 32'(addr_err), 32'(CHK));
        tick();
        for (int j = 0; j < 3; j++) begin
            settle();
            check("err_sticky", 32'(addr_err), 32'(CHK));
            tick();
        end
        core_addr[2*ADDR_LEN +: ADDR_LEN] = ADDR_LEN'(6);
        for (int k = 0; k < 7; k++) begin
            core_valid = 4'b0001;
            settle();
            check("oor_fill_grant", 32'(core_ready), 32'd1);
            tick();
        end
        core_valid = '0;
        settle();
        check("oor_count", 32'(wait_vsync), CHK ? 32'd0 : 32'd1);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/frame_write_scheduler.md
Name: frame_write_scheduler

Overview:
- Sits between the ray-marcher cores and the write port of bram_manager.
- Arbitrates pixel writes from NUM_CORES cores into the back buffer using round-robin, one write per cycle.
- Counts the pixels written in the current frame. Once FRAME_PIXELS pixels are written, it stalls the cores, waits for the start of vertical sync, then pulses swap_buffers so the finished frame becomes the front buffer.

Parameters:
- NUM_CORES, 4, number of requesting render cores (≥2).
- WIDTH, 4, pixel data width; matches the bram_manager WIDTH.
- ADDR_LEN, 17, pixel address width; matches the bram_manager ADDR_LEN.
- FRAME_PIXELS, 76800, writes per frame before a swap (≤ 2^ADDR_LEN).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- core_valid  in  NUM_CORES  per-core write request.
- core_addr  in  NUM_CORES*ADDR_LEN  per-core pixel address; core i occupies bits [i*ADDR_LEN +: ADDR_LEN].
- core_data  in  NUM_CORES*WIDTH  per-core pixel value; core i occupies bits [i*WIDTH +: WIDTH].
- core_ready  out  NUM_CORES  per-core accept; at most one bit high.
- vsync_in  in  1  VGA vertical sync, active-low, same clock domain.
- write_enable  out  1  to bram_manager write_enable.
- write_addr  out  ADDR_LEN  to bram_manager write_addr.
- write_data  out  WIDTH  to bram_manager write_data.
- swap_buffers  out  1  one-cycle swap pulse to bram_manager.
- frame_count  out  16  number of completed swaps; wraps at 65535→0.
- wait_vsync  out  1  high while a finished frame is waiting to be swapped.
- addr_err  out  1  sticky error flag; exists only with the optional feature.

Behaviour:

Reset (rst sampled high on a clk edge):
- State = RENDER. Pixel count = 0. RR pointer = 0. frame_count = 0.
- write_enable, swap_buffers, wait_vsync, addr_err = 0.
- write_addr and write_data = 0.
- core_ready = 0 during the reset cycle.
- Reset mid-frame discards the partial count; no swap is issued.

States:
- RENDER: arbitrate.
  - When an accepted write brings the count to FRAME_PIXELS, go to WAIT_VSYNC on the next cycle.
- WAIT_VSYNC: core_ready = 0, wait_vsync = 1.
  - On the first falling edge of vsync_in, detected as registered previous value 1 and current value 0, go to SWAP.
  - A falling edge is required. Entering this state while vsync_in is already low waits for the next frame's edge.
- SWAP: swap_buffers = 1 for exactly this cycle.
  - frame_count increments, pixel count clears, go to RENDER.
  - core_ready = 0 in this state.

Arbitration (RENDER only):
- core_ready is combinational.
- Grant goes to the first i with core_valid[i]=1, searching from the RR pointer upward with wrap-around.
- A transfer occurs when core_valid[i] && core_ready[i].
- After a grant to core i, the pointer becomes (i+1) mod NUM_CORES.
- With no valid core, no grant is made and the pointer holds.
- Cores must hold addr/data stable while valid is high and not yet accepted.

Write port:
- Registered; latency 1 cycle.
- write_enable = 1 in the cycle after an accept, with the accepted addr/data; otherwise 0.
- write_addr and write_data hold their last value when write_enable = 0.
- Throughput is one write per cycle.

Pixel count:
- Width is ADDR_LEN+1 bits and increments per accept.
- The final accept (count FRAME_PIXELS-1 → FRAME_PIXELS) still writes.
- Its write_enable falls in the first WAIT_VSYNC cycle, before swap_buffers. swap_buffers is never coincident with write_enable.

Duplicate addresses:
- These are not detected; each accept counts.

Optional Feature:

Macro: FRAME_WRITE_ADDR_CHECK_EN

Defined:
- An accepted request with addr ≥ FRAME_PIXELS is consumed: ready is given and the pointer advances.
- It produces no write_enable and does not increment the count.
- It sets addr_err, which stays high until rst.

Undefined:
- No range check; every accept writes and counts.
- addr_err is tied to 0.

Test Plan:
- Reset with all cores valid for 1 cycle, then rst low → first grant to core 0. write_enable first high 1 cycle after the first accept (addr/data of core 0). frame_count=0.
- NUM_CORES=4, all valid continuously, distinct addrs → grant order 0,1,2,3,0,… with exactly one write per cycle. Dropping core_valid[1] only → order 0,2,3,0.
- FRAME_PIXELS=8, vsync_in held high → after 8 accepts, core_ready=0 and wait_vsync=1 indefinitely. vsync_in 1→0 → swap_buffers high exactly one cycle, 2 cycles after the edge. frame_count=1; RENDER resumes with count 0.
- FRAME_PIXELS=8, vsync_in already low when the 8th accept occurs → no swap until vsync_in goes high then low again.
- Assert rst in WAIT_VSYNC after 8 accepts → no swap_buffers. frame_count=0. A full new frame of 8 accepts is required before the next swap.
- With FRAME_WRITE_ADDR_CHECK_EN, FRAME_PIXELS=8: core 2 sends addr 9 → ready granted, no write, count unchanged, addr_err=1 and sticky. Without the macro, the same stimulus writes addr 9 and counts it.
